// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory behind a valid/ready request/response pair
// with fixed latency. Define DMEM_ALIGN_CHECK_EN to reject accesses not aligned to their size.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [3:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_wr;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [3:0]  r_size;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic [63:0] r_resp_rdata;
   logic [7:0]  r_mem [DEPTH];

   logic          w_size_err;
   logic          w_range_err;
   logic          w_align_err;
   logic          w_err;
   logic [64:0]   w_end;
   logic [6:0]    w_shift;
   logic [63:0]   w_rd_be;
   logic [63:0]   w_rdata;
   logic [63:0]   w_wr_al;
   logic [7:0]    w_byte_en;
   logic [AW-1:0] w_idx [8];
   logic          w_complete;

   assign w_size_err  = !((r_size == 4'd1) || (r_size == 4'd2) ||
                          (r_size == 4'd4) || (r_size == 4'd8));
   // 65-bit end address so a request near 2^64-1 cannot wrap into range
   assign w_end       = {1'b0, r_addr} + {61'd0, r_size};
   assign w_range_err = (r_addr >= 64'(DEPTH)) || (w_end > 65'(DEPTH));

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_align_err = |(r_addr[3:0] & (r_size - 4'd1));
`else
   assign w_align_err = 1'b0;
`endif

   assign w_err      = w_size_err | w_range_err | w_align_err;
   assign w_complete = (r_state == BUSY) && (r_cnt == 4'd0);

   // Byte k of the 8-byte window is the k-th most significant; shifting by
   // 8*(8-S) right-justifies an S-byte read and left-aligns an S-byte write.
   assign w_shift = {(4'd8 - r_size), 3'b000};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign w_idx[gi]              = r_addr[AW-1:0] + AW'(gi);
         assign w_rd_be[63-8*gi -: 8]  = r_mem[w_idx[gi]];
         assign w_byte_en[gi]          = (4'(gi) < r_size);
      end
   endgenerate

   assign w_rdata = w_rd_be >> w_shift;
   assign w_wr_al = r_wdata << w_shift;

   // Memory has no reset so contents survive rst; the write lands on the completion edge only
   always_ff @(posedge clk) begin
      if (rst && w_complete && r_wr && !w_err) begin
         for (int k = 0; k < 8; k++) begin
            if (w_byte_en[k]) r_mem[w_idx[k]] <= w_wr_al[8*(7-k) +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_cnt        <= 4'd0;
         r_wr         <= 1'b0;
         r_addr       <= 64'd0;
         r_wdata      <= 64'd0;
         r_size       <= 4'd0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 64'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_wr        <= req_wr;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_size      <= req_size;
                  r_cnt       <= 4'(LATENCY - 1);
                  r_req_ready <= 1'b0;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= w_err;
                  r_resp_rdata <= (w_err || r_wr) ? 64'd0 : w_rdata;
                  r_state      <= RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= 64'd0;
                  r_req_ready  <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios then random traffic,
// expectations from a byte-array reference model.
module tb_data_mem_responder;
   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic [3:0]  req_size = 4'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic        resp_err;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rr_mode = 0;
   exp_t sb[$];
   logic [7:0] mdl [DEPTH];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // resp_ready: 0 = always accept, 1 = random back-pressure, 2 = hold off
   initial forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
         0:       resp_ready = 1'b1;
         1:       resp_ready = ($urandom_range(0, 3) != 0);
         default: resp_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Reference: legal size, fits below DEPTH, optional alignment; big-endian byte walk
   task automatic model(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [3:0] s, output exp_t e);
      int n;
      n = int'(s);
      e.rdata = 64'd0;
      e.err   = 1'b0;
      e.due   = 0;
      if (!(n == 1 || n == 2 || n == 4 || n == 8)) e.err = 1'b1;
      else if (a >= 64'(DEPTH) || 64'(n) > 64'(DEPTH) - a) e.err = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
      else if ((a % 64'(n)) != 64'd0) e.err = 1'b1;
`endif
      if (!e.err) begin
         for (int k = 0; k < n; k++) begin
            if (wr) mdl[int'(a[31:0]) + k] = 8'(wd >> (8 * (n - 1 - k)));
            else    e.rdata = (e.rdata << 8) | 64'(mdl[int'(a[31:0]) + k]);
         end
      end
   endtask

   task automatic do_req(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                         input logic [3:0] s, input bit push);
      exp_t e;
      int   budget;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = wd;
      req_size  = s;
      budget    = 200;
      while (!req_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!req_ready) begin
         timeout_fail("req_ready_wait");
         req_valid = 1'b0;
         return;
      end
      if (push) begin
         model(wr, a, wd, s, e);
         e.due = cyc + 1 + LATENCY;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      // junk on the request bus while busy must be ignored
      req_wr    = ~wr;
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_size  = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 500;
      while ((sb.size() != 0 || resp_valid) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) timeout_fail("drain");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
      check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
   endtask

   // Monitor: compares on each rising resp_valid, and checks hold/handshake behaviour
   initial begin
      bit          prev_v = 1'b0;
      bit          prev_hs = 1'b0;
      logic [63:0] held_d = 64'd0;
      logic        held_e = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (prev_hs) begin
               check("req_ready_after_resp", 64'(req_ready), 64'd1);
               check("resp_valid_cleared", 64'(resp_valid), 64'd0);
            end else if (prev_v) begin
               check("resp_valid_hold", 64'(resp_valid), 64'd1);
               check("resp_rdata_hold", resp_rdata, held_d);
               check("resp_err_hold", 64'(resp_err), 64'(held_e));
               check("req_ready_low_in_resp", 64'(req_ready), 64'd0);
            end
            if (resp_valid && (!prev_v || prev_hs)) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_resp: got rdata=%h err=%0d expected none",
                           resp_rdata, resp_err);
               end else begin
                  e = sb.pop_front();
                  $display("resp rdata=%h err=%0d cycle=%0d", resp_rdata, resp_err, cyc);
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_err", 64'(resp_err), 64'(e.err));
                  check("resp_latency", 64'(cyc), 64'(e.due));
               end
            end
            prev_v  = resp_valid;
            prev_hs = resp_valid && resp_ready;
            held_d  = resp_rdata;
            held_e  = resp_err;
         end
      end
   end

   initial begin
      logic [63:0] a;
      logic [63:0] wd;
      logic [3:0]  s;
      int          budget;

      #3 rst = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rr_mode = 0;

      // write then read back, and partial reads/writes around it
      do_req(1'b1, 64'd16, 64'h0123456789ABCDEF, 4'd8, 1'b1);
      do_req(1'b0, 64'd16, 64'd0, 4'd8, 1'b1);
      do_req(1'b0, 64'd17, 64'd0, 4'd1, 1'b1);
      do_req(1'b1, 64'd18, 64'h00000000DEADBEEF, 4'd2, 1'b1);
      do_req(1'b0, 64'd16, 64'd0, 4'd8, 1'b1);
      drain();

      // hold off the response for five cycles
      rr_mode = 2;
      do_req(1'b0, 64'd16, 64'd0, 4'd8, 1'b1);
      budget = 50;
      while (!resp_valid && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!resp_valid) timeout_fail("hold_resp_wait");
      repeat (5) @(negedge clk);
      rr_mode = 0;
      drain();

      // out-of-range and wrap-around requests
      do_req(1'b0, 64'd1020, 64'd0, 4'd8, 1'b1);
      do_req(1'b0, 64'd1024, 64'd0, 4'd4, 1'b1);
      do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd5, 4'd8, 1'b1);
      do_req(1'b0, 64'd0, 64'd0, 4'd3, 1'b1);
      drain();

      // fill memory so every later read has a known value
      for (int i = 0; i < DEPTH; i += 8) begin
         do_req(1'b1, 64'(i), {$urandom, $urandom}, 4'd8, 1'b1);
      end
      drain();

      // unaligned 8-byte write at 4 then read back both neighbours
      do_req(1'b1, 64'd4, {$urandom, $urandom}, 4'd8, 1'b1);
      do_req(1'b0, 64'd0, 64'd0, 4'd8, 1'b1);
      do_req(1'b0, 64'd8, 64'd0, 4'd8, 1'b1);
      do_req(1'b0, 64'd4, 64'd0, 4'd8, 1'b1);
      drain();

      // reset one cycle after accepting a write: the write must be abandoned
      do_req(1'b1, 64'd16, 64'hFFFFFFFFFFFFFFFF, 4'd8, 1'b0);
      rst = 1'b0;
      #1 check_reset_outputs("mid_reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_req(1'b0, 64'd16, 64'd0, 4'd8, 1'b1);
      drain();

      // random traffic with random back-pressure
      rr_mode = 1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0:       a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            1:       a = 64'(DEPTH - 8 + $urandom_range(0, 15));
            default: a = 64'($urandom_range(0, DEPTH - 1));
         endcase
         if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(0, 15));
         else                           s = 4'(1 << $urandom_range(0, 3));
         wd = {$urandom, $urandom};
         do_req(1'($urandom_range(0, 1)), a, wd, s, 1'b1);
      end
      rr_mode = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
